jtag_spi_framer: RTL

JTAG_SPI_FRAMER -- requirements
Module: jtag_spi_framer

---
 rtl/jtag_spi_framer.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/jtag_spi_framer.sv
// ---------------------------------------------------------------------------
// jtag_spi_framer
//
// Purpose:
//   Bridges a BSCAN USER data register to a SPI flash. The host first shifts
//   a header carrying the payload length in SPI bits, LSB first. The framer
//   then clocks that many payload bits to the flash while returning the
//   flash's MISO bits on tdo, delayed by one DR bit.
//
// Optional feature (macro JSF_CSN_HOLD_EN):
//   The header grows to LEN_W+1 bits. Bit LEN_W is a hold flag that keeps
//   csn low after the frame ends, so several frames can form one flash
//   transaction.
//
// Ports:
//   drck      in  gated TCK from BSCAN, the only clock (rising edge)
//   reset     in  asynchronous active-high reset
//   sel       in  USER instruction active
//   capture   in  Capture-DR strobe
//   shift     in  Shift-DR strobe
//   update    in  Update-DR strobe
//   tdi       in  DR shift data, LSB first
//   tdo       out DR readback (delayed MISO during payload, else 0)
//   csn       out flash chip select, active low
//   sck_en    out SPI clock enable (SPI clock = ~drck & sck_en)
//   sdi_dq0   out MOSI
//   sdo_dq1   in  MISO
//   wpn_dq2   out write protect, tied high
//   hldn_dq3  out hold, tied high
//   abort     out one-cycle pulse when a frame is truncated by update
// ---------------------------------------------------------------------------
module jtag_spi_framer #(
  parameter int LEN_W = 16
) (
  input  logic drck,
  input  logic reset,
  input  logic sel,
  input  logic capture,
  input  logic shift,
  input  logic update,
  input  logic tdi,
  output logic tdo,
  output logic csn,
  output logic sck_en,
  output logic sdi_dq0,
  input  logic sdo_dq1,
  output logic wpn_dq2,
  output logic hldn_dq3,
  output logic abort
);

`ifdef JSF_CSN_HOLD_EN
  localparam int HDR_W = LEN_W + 1;
`else
  localparam int HDR_W = LEN_W;
`endif
  localparam int CNT_W = $clog2(HDR_W + 1);

  typedef enum logic [1:0] {IDLE, HDR, XFER, DONE} state_t;

  state_t           r_state;
  state_t           w_stateNext;
  logic [HDR_W-2:0] r_hdr;
  logic [CNT_W-1:0] r_bitCnt;
  logic [LEN_W-1:0] r_remain;
  logic             r_csn;
  logic             r_sdi;
  logic             r_tdo;
  logic             r_abort;
  logic             r_hold;

  logic [HDR_W-1:0] w_hdrShifted;
  logic [LEN_W-1:0] w_len;
  logic             w_holdBit;
  logic             w_upd;
  logic             w_cap;
  logic             w_shf;
  logic             w_hdrDone;
  logic             w_xferShift;
  logic             w_abort;

  // Strobe decode with update > capture > shift priority; sel=0 masks all.
  assign w_upd = sel & update;
  assign w_cap = sel & capture & ~update;
  assign w_shf = sel & shift & ~capture & ~update;

  // The header register keeps only the bits received so far; the final bit
  // is taken straight from tdi on the completion cycle.
  assign w_hdrShifted = {tdi, r_hdr};
  assign w_len        = w_hdrShifted[LEN_W-1:0];
`ifdef JSF_CSN_HOLD_EN
  assign w_holdBit    = w_hdrShifted[LEN_W];
`else
  assign w_holdBit    = 1'b0;
`endif

  assign w_hdrDone   = (r_state == HDR) && w_shf && (r_bitCnt == CNT_W'(HDR_W - 1));
  assign w_xferShift = (r_state == XFER) && w_shf && (r_remain != '0);
  // Once the count has run out the frame is complete, so update is no
  // longer a truncation.
  assign w_abort     = w_upd && ((r_state == HDR) ||
                                 ((r_state == XFER) && (r_remain != '0)));

  assign sck_en   = w_xferShift;
  assign csn      = r_csn;
  assign sdi_dq0  = r_sdi;
  assign tdo      = r_tdo;
  assign abort    = r_abort;
  assign wpn_dq2  = 1'b1;
  assign hldn_dq3 = 1'b1;

  // State register for the framing FSM.
  always_ff @(posedge drck or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Next-state logic. XFER lingers one shift after the count reaches zero
  // so the last MISO bit can still be read out on tdo.
  always_comb begin
    w_stateNext = r_state;
    if (w_upd) begin
      w_stateNext = IDLE;
    end else if (w_cap) begin
      w_stateNext = HDR;
    end else if (w_hdrDone) begin
      w_stateNext = (w_len == '0) ? DONE : XFER;
    end else if ((r_state == XFER) && w_shf && (r_remain == '0)) begin
      w_stateNext = DONE;
    end
  end

  // Datapath: header assembly, remaining count, chip select, MOSI/MISO
  // registers and the abort pulse.
  always_ff @(posedge drck or posedge reset) begin
    if (reset) begin
      r_hdr    <= '0;
      r_bitCnt <= '0;
      r_remain <= '0;
      r_csn    <= 1'b1;
      r_sdi    <= 1'b0;
      r_tdo    <= 1'b0;
      r_abort  <= 1'b0;
      r_hold   <= 1'b0;
    end else begin
      r_abort <= 1'b0;
      if (w_upd) begin
        r_tdo <= 1'b0;
        if (w_abort) begin
          r_csn   <= 1'b1;
          r_hold  <= 1'b0;
          r_abort <= 1'b1;
        end
      end else if (w_cap) begin
        r_hdr    <= '0;
        r_bitCnt <= '0;
        r_tdo    <= 1'b0;
        if (r_state == XFER) begin
          r_csn  <= 1'b1;
          r_hold <= 1'b0;
        end
      end else if (w_shf) begin
        case (r_state)
          HDR: begin
            r_hdr    <= w_hdrShifted[HDR_W-1:1];
            r_bitCnt <= r_bitCnt + CNT_W'(1);
            if (w_hdrDone) begin
              r_remain <= w_len;
              if (w_len != '0) begin
                r_csn  <= 1'b0;
                r_hold <= w_holdBit;
              end else if (!w_holdBit) begin
                r_csn  <= 1'b1;
                r_hold <= 1'b0;
              end
            end
          end
          XFER: begin
            if (r_remain != '0) begin
              r_sdi    <= tdi;
              r_tdo    <= sdo_dq1;
              r_remain <= r_remain - LEN_W'(1);
              if ((r_remain == LEN_W'(1)) && !r_hold) begin
                r_csn <= 1'b1;
              end
            end else begin
              r_tdo <= 1'b0;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule
